controle_separacao: RTL and testbench

Sequencing controller for the waste-sorting bins. It sits between the two item detectors and the recyclable/non-recyclable bin counters. It latches detection events and arbitrates between the two classes, then opens one sorting gate at a time for a fixed number of cycles. At the end of each gate opening it pulses the matching counter's increment. It keeps occupancy shadows so it can refuse items for a full bin and report them as dropped.

---
 rtl/controle_separacao.sv | 159 +++++++++++++++
 tb/tb_controle_separacao.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_separacao.sv
// ============================================================================
// controle_separacao : waste-sorting gate sequencer with bin occupancy shadows
// Option macro: SEPARACAO_PRIORIDADE_EN (fixed NREC priority).  Rev 1.0
// ============================================================================
`default_nettype none

module controle_separacao #(
   parameter int GATE_CYCLES = 4,
   parameter int CAP         = 7,
   parameter int CNT_W       = 3
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             det_rec,
   input  logic             det_nrec,
   input  logic             esvaziar_rec,
   input  logic             esvaziar_nrec,
   output logic             gate_rec,
   output logic             gate_nrec,
   output logic             inc_rec,
   output logic             inc_nrec,
   output logic [CNT_W-1:0] cnt_rec,
   output logic [CNT_W-1:0] cnt_nrec,
   output logic             full_rec,
   output logic             full_nrec,
   output logic             busy,
   output logic             err_drop
);

   localparam int               c_TW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [c_TW-1:0]  c_TLAST = c_TW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CAP   = CNT_W'(CAP);
   localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_OPEN_REC  = 2'd1,
      S_OPEN_NREC = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   state_t           r_state;
   logic [c_TW-1:0]  r_timer;
   logic             r_pend_rec;
   logic             r_pend_nrec;
   logic [CNT_W-1:0] r_cnt_rec;
   logic [CNT_W-1:0] r_cnt_nrec;
   logic             r_err;
`ifndef SEPARACAO_PRIORIDADE_EN
   logic             r_ultimo_nrec;
`endif

   logic w_idle;
   logic w_pick_rec;
   logic w_pick_nrec;
   logic w_full_rec;
   logic w_full_nrec;
   logic w_grant_rec;
   logic w_grant_nrec;
   logic w_refuse_rec;
   logic w_refuse_nrec;
   logic w_drop_rec;
   logic w_drop_nrec;
   logic w_last_tick;

   assign w_idle      = (r_state == S_IDLE);
   assign w_full_rec  = (r_cnt_rec == c_CAP);
   assign w_full_nrec = (r_cnt_nrec == c_CAP);
   assign w_last_tick = (r_timer == c_TLAST);

`ifdef SEPARACAO_PRIORIDADE_EN
   assign w_pick_rec  = w_idle & r_pend_rec & ~r_pend_nrec;
   assign w_pick_nrec = w_idle & r_pend_nrec;
`else
   // With both pending, serve the class that was not granted last.
   assign w_pick_rec  = w_idle & r_pend_rec  & (~r_pend_nrec | r_ultimo_nrec);
   assign w_pick_nrec = w_idle & r_pend_nrec & (~r_pend_rec  | ~r_ultimo_nrec);
`endif

   assign w_grant_rec   = w_pick_rec  & ~w_full_rec;
   assign w_grant_nrec  = w_pick_nrec & ~w_full_nrec;
   assign w_refuse_rec  = w_pick_rec  & w_full_rec;
   assign w_refuse_nrec = w_pick_nrec & w_full_nrec;

   // A selection consumes the old request, so a coincident detection is not a drop.
   assign w_drop_rec  = det_rec  & r_pend_rec  & ~w_pick_rec;
   assign w_drop_nrec = det_nrec & r_pend_nrec & ~w_pick_nrec;

   assign gate_rec  = (r_state == S_OPEN_REC);
   assign gate_nrec = (r_state == S_OPEN_NREC);
   assign inc_rec   = gate_rec  & w_last_tick;
   assign inc_nrec  = gate_nrec & w_last_tick;
   assign busy      = ~w_idle;
   assign cnt_rec   = r_cnt_rec;
   assign cnt_nrec  = r_cnt_nrec;
   assign full_rec  = w_full_rec;
   assign full_nrec = w_full_nrec;
   assign err_drop  = r_err;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_pend_rec    <= 1'b0;
         r_pend_nrec   <= 1'b0;
         r_cnt_rec     <= '0;
         r_cnt_nrec    <= '0;
         r_err         <= 1'b0;
`ifndef SEPARACAO_PRIORIDADE_EN
         r_ultimo_nrec <= 1'b1;
`endif
      end else begin
         r_err       <= w_drop_rec | w_drop_nrec | w_refuse_rec | w_refuse_nrec;
         r_pend_rec  <= det_rec  | (r_pend_rec  & ~w_pick_rec);
         r_pend_nrec <= det_nrec | (r_pend_nrec & ~w_pick_nrec);

         // Emptying overrides a coincident increment.
         if (esvaziar_rec)
            r_cnt_rec <= '0;
         else if (inc_rec)
            r_cnt_rec <= r_cnt_rec + c_ONE;

         if (esvaziar_nrec)
            r_cnt_nrec <= '0;
         else if (inc_nrec)
            r_cnt_nrec <= r_cnt_nrec + c_ONE;

         case (r_state)
            S_IDLE: begin
               r_timer <= '0;
               if (w_grant_rec) begin
                  r_state <= S_OPEN_REC;
`ifndef SEPARACAO_PRIORIDADE_EN
                  r_ultimo_nrec <= 1'b0;
`endif
               end else if (w_grant_nrec) begin
                  r_state <= S_OPEN_NREC;
`ifndef SEPARACAO_PRIORIDADE_EN
                  r_ultimo_nrec <= 1'b1;
`endif
               end
            end
            S_OPEN_REC, S_OPEN_NREC: begin
               if (w_last_tick) begin
                  r_state <= S_GAP;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_GAP:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_controle_separacao.sv
// ============================================================================
// tb_controle_separacao : bench for controle_separacao (table, directed, random)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_controle_separacao;

   localparam int G   = 4;
   localparam int CAP = 7;
   localparam int W   = 3;

   logic         clock = 1'b0;
   logic         clear;
   logic         det_rec, det_nrec, esv_rec, esv_nrec;
   logic         gate_rec, gate_nrec, inc_rec, inc_nrec;
   logic [W-1:0] cnt_rec, cnt_nrec;
   logic         full_rec, full_nrec, busy, err_drop;

   controle_separacao #(.GATE_CYCLES(G), .CAP(CAP), .CNT_W(W)) dut (
      .clock         (clock),
      .clear         (clear),
      .det_rec       (det_rec),
      .det_nrec      (det_nrec),
      .esvaziar_rec  (esv_rec),
      .esvaziar_nrec (esv_nrec),
      .gate_rec      (gate_rec),
      .gate_nrec     (gate_nrec),
      .inc_rec       (inc_rec),
      .inc_nrec      (inc_nrec),
      .cnt_rec       (cnt_rec),
      .cnt_nrec      (cnt_nrec),
      .full_rec      (full_rec),
      .full_nrec     (full_nrec),
      .busy          (busy),
      .err_drop      (err_drop)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: item-level view (phase = cycles since grant, -1 when idle)
   int m_pend [2];
   int m_cnt  [2];
   int m_last;
   int m_phase;
   int m_cls;
   bit m_err;

   int first_gate;
   int seen_gn;
   int n_err;

   typedef struct packed {
      logic [3:0]  in;
      logic [13:0] exp;
   } vec_t;
   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void model_reset();
      m_pend[0] = 0; m_pend[1] = 0;
      m_cnt[0]  = 0; m_cnt[1]  = 0;
      m_last    = 1;
      m_phase   = -1;
      m_cls     = 0;
      m_err     = 1'b0;
   endfunction

   function automatic void model_edge(input bit dr, input bit dn, input bit er, input bit en);
      bit det [2];
      bit esv [2];
      int sel;
      bit grant;
      det[0] = dr; det[1] = dn;
      esv[0] = er; esv[1] = en;
      sel   = -1;
      grant = 1'b0;
      m_err = 1'b0;
      if (m_phase < 0) begin
         if (m_pend[0] != 0 && m_pend[1] != 0) begin
`ifdef SEPARACAO_PRIORIDADE_EN
            sel = 1;
`else
            sel = (m_last == 0) ? 1 : 0;
`endif
         end else if (m_pend[0] != 0) sel = 0;
         else if (m_pend[1] != 0) sel = 1;
      end
      if (sel >= 0) begin
         if (m_cnt[sel] == CAP) m_err = 1'b1;
         else grant = 1'b1;
      end
      for (int c = 0; c < 2; c++)
         if (det[c] && m_pend[c] != 0 && sel != c) m_err = 1'b1;
      if (sel >= 0) m_pend[sel] = 0;
      for (int c = 0; c < 2; c++)
         if (det[c]) m_pend[c] = 1;
      if (m_phase == G - 1) m_cnt[m_cls] = m_cnt[m_cls] + 1;
      for (int c = 0; c < 2; c++)
         if (esv[c]) m_cnt[c] = 0;
      if (m_phase >= 0) m_phase = (m_phase == G) ? -1 : m_phase + 1;
      else if (grant) begin
         m_phase = 0;
         m_cls   = sel;
         m_last  = sel;
      end
   endfunction

   function automatic logic [13:0] model_out();
      logic gr, gn;
      gr = (m_phase >= 0) && (m_phase < G) && (m_cls == 0);
      gn = (m_phase >= 0) && (m_phase < G) && (m_cls == 1);
      return {gr, gn, gr && (m_phase == G - 1), gn && (m_phase == G - 1),
              m_phase >= 0, m_err, m_cnt[0] == CAP, m_cnt[1] == CAP,
              3'(m_cnt[0]), 3'(m_cnt[1])};
   endfunction

   function automatic logic [13:0] dut_out();
      return {gate_rec, gate_nrec, inc_rec, inc_nrec, busy, err_drop,
              full_rec, full_nrec, cnt_rec, cnt_nrec};
   endfunction

   task automatic step(input bit dr, input bit dn, input bit er, input bit en);
      @(negedge clock);
      det_rec = dr; det_nrec = dn; esv_rec = er; esv_nrec = en;
      @(posedge clock);
      model_edge(dr, dn, er, en);
      #1;
      check("step", dut_out(), model_out());
      if (first_gate < 0) begin
         if (gate_rec) first_gate = 0;
         else if (gate_nrec) first_gate = 1;
      end
      if (gate_nrec) seen_gn++;
      if (err_drop)  n_err++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      det_rec = 1'b0; det_nrec = 1'b0; esv_rec = 1'b0; esv_nrec = 1'b0;
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      model_reset();
      first_gate = -1; seen_gn = 0; n_err = 0;
      #1;
      check("reset", dut_out(), 14'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // {det_rec,det_nrec,esv_rec,esv_nrec} -> {gr,gn,ir,in,busy,err,fr,fn,cnt_rec,cnt_nrec}
      tbl[0]  = '{4'b1000, {6'b000000, 2'b00, 3'd0, 3'd0}};
      tbl[1]  = '{4'b0000, {6'b100010, 2'b00, 3'd0, 3'd0}};
      tbl[2]  = '{4'b0000, {6'b100010, 2'b00, 3'd0, 3'd0}};
      tbl[3]  = '{4'b0000, {6'b100010, 2'b00, 3'd0, 3'd0}};
      tbl[4]  = '{4'b0000, {6'b101010, 2'b00, 3'd0, 3'd0}};
      tbl[5]  = '{4'b0000, {6'b000010, 2'b00, 3'd1, 3'd0}};
      tbl[6]  = '{4'b0000, {6'b000000, 2'b00, 3'd1, 3'd0}};
      tbl[7]  = '{4'b0100, {6'b000000, 2'b00, 3'd1, 3'd0}};
      tbl[8]  = '{4'b0000, {6'b010010, 2'b00, 3'd1, 3'd0}};
      tbl[9]  = '{4'b0000, {6'b010010, 2'b00, 3'd1, 3'd0}};
      tbl[10] = '{4'b0000, {6'b010010, 2'b00, 3'd1, 3'd0}};
      tbl[11] = '{4'b0000, {6'b010110, 2'b00, 3'd1, 3'd0}};
      tbl[12] = '{4'b0000, {6'b000010, 2'b00, 3'd1, 3'd1}};
      tbl[13] = '{4'b0000, {6'b000000, 2'b00, 3'd1, 3'd1}};

      clear = 1'b1;
      det_rec = 1'b0; det_nrec = 1'b0; esv_rec = 1'b0; esv_nrec = 1'b0;
      first_gate = -1; seen_gn = 0; n_err = 0;
      model_reset();
      repeat (2) @(posedge clock);

      // Single REC item then single NREC item, against hand-derived table
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
         check("table", dut_out(), tbl[i].exp);
      end

      // Simultaneous detections: arbitration order
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(14);
`ifdef SEPARACAO_PRIORIDADE_EN
      check("t2_first_class", first_gate, 1);
`else
      check("t2_first_class", first_gate, 0);
`endif
      check("t2_counts", {cnt_rec, cnt_nrec}, {3'd1, 3'd1});

      // Second REC detection while the first is still waiting
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      n_err = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(12);
      check("t3_err_pulses", n_err, 1);
      check("t3_counts", {cnt_rec, cnt_nrec}, {3'd1, 3'd1});

      // Fill NREC bin, then refusal of the 8th item, then empty
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         idle(6);
      end
      check("t4_full", {full_nrec, cnt_nrec}, {1'b1, 3'd7});
      seen_gn = 0; n_err = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);
      check("t4_refuse_err", n_err, 1);
      check("t4_no_gate", seen_gn, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("t4_emptied", {full_nrec, cnt_nrec}, {1'b0, 3'd0});

      // Empty coinciding with the increment cycle
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         idle(6);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 10 && !inc_rec; n++) idle(1);
      check("t5_inc_cycle", {inc_rec, cnt_rec}, {1'b1, 3'd3});
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("t5_cnt_zero", cnt_rec, 3'd0);

      // Asynchronous clear while a gate is open
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("t6_gate_open", gate_nrec, 1'b1);
      #2 clear = 1'b1;
      #1 check("t6_async_clear", dut_out(), 14'd0);
      @(negedge clock);
      clear = 1'b0;
      model_reset();
      seen_gn = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);
      check("t6_gate_cycles", seen_gn, G);
      check("t6_cnt", cnt_nrec, 3'd1);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
